disp2c_num: RTL and testbench

//   Captures an 8-bit two's-complement operand and shows it in signed decimal on four

---
 rtl/disp2c_num.sv | 96 +++++++++
 tb/tb_disp2c_num.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/disp2c_num.sv
// Signed decimal display for an 8-bit two's-complement operand on four active-low
// 7-segment digits, converted by a sequential shift-add-3 FSM.
module disp2c_num (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] x,
  input  logic       enable,
  output logic [6:0] H0,
  output logic [6:0] H1,
  output logic [6:0] H2,
  output logic [6:0] H3
);

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_ONE   = 7'b1111001;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  state_t     state;
  logic       sign;
  logic [7:0] mag;
  // |x| never exceeds 128, so the hundreds digit is a single bit (bcd[8]).
  logic [8:0] bcd;
  logic [2:0] count;
  logic [7:0] bcd_adj;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // NOTE: combinational blocks assign every output unconditionally so no latch is inferred.
  always_comb begin
    bcd_adj = {add3(bcd[7:4]), add3(bcd[3:0])};
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      sign  <= 1'b0;
      mag   <= '0;
      bcd   <= '0;
      count <= '0;
      H0    <= SEG_ZERO;
      H1    <= SEG_BLANK;
      H2    <= SEG_BLANK;
      H3    <= SEG_BLANK;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            sign  <= x[7];
            // Unsigned 8 bits hold 128, so negating -128 needs no extra bit.
            mag   <= x[7] ? (~x + 8'd1) : x;
            bcd   <= '0;
            count <= '0;
            state <= CONV;
          end
        end
        CONV: begin
          bcd   <= {bcd_adj, mag[7]};
          mag   <= {mag[6:0], 1'b0};
          count <= count + 3'd1;
          if (count == 3'd7) state <= LOAD;
        end
        LOAD: begin
          H0    <= seg7(bcd[3:0]);
          H1    <= (!bcd[8] && bcd[7:4] == 4'd0) ? SEG_BLANK : seg7(bcd[7:4]);
          H2    <= bcd[8] ? SEG_ONE : SEG_BLANK;
          H3    <= sign ? SEG_MINUS : SEG_BLANK;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_disp2c_num.sv
// Scoreboard bench for disp2c_num: stimulus queues expected displays tagged with the
// edge after which they must be visible; a negedge monitor pops and compares.
module tb_disp2c_num;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] x;
  logic       enable;
  logic [6:0] H0, H1, H2, H3;

  disp2c_num dut (
    .clk    (clk),
    .resetn (resetn),
    .x      (x),
    .enable (enable),
    .H0     (H0),
    .H1     (H1),
    .H2     (H2),
    .H3     (H3)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S5 = 7'b0010010, S7 = 7'b1111000,
                         S8 = 7'b0000000, MI = 7'b0111111, BL = 7'b1111111;
  // Display vectors are {H3, H2, H1, H0}.
  localparam logic [27:0] D_RST = {BL, BL, BL, S0};

  typedef struct {
    int          due;
    logic [27:0] disp;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          edge_cnt = 0;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [27:0] cur;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Monitor: compare each expectation at the negedge following its due edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= edge_cnt) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      if (e.due < edge_cnt) begin
        n_fail++;
        $display("FAIL %s: check missed (due edge %0d, now %0d)", e.name, e.due, edge_cnt);
      end else if ({H3, H2, H1, H0} !== e.disp) begin
        n_fail++;
        $display("FAIL %s: got H3..H0=%b_%b_%b_%b expected %b_%b_%b_%b", e.name,
                 H3, H2, H1, H0, e.disp[27:21], e.disp[20:14], e.disp[13:7], e.disp[6:0]);
      end
    end
  end

  task automatic push(input int due, input logic [27:0] disp, input string nm);
    exp_t e;
    e.due = due; e.disp = disp; e.name = nm;
    sb.push_back(e);
  endtask

  // One-cycle enable pulse; the display must be unchanged after edge N+8 and new after N+9.
  task automatic capture(input logic [7:0] val, input logic [27:0] exp_disp, input string nm);
    int e0;
    e0 = edge_cnt;
    x = val;
    enable = 1'b1;
    push(e0 + 9, cur, {nm, "_hold"});
    push(e0 + 10, exp_disp, nm);
    @(negedge clk);
    enable = 1'b0;
    x = ~val;
    cur = exp_disp;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    resetn = 1'b0;
    enable = 1'b0;
    x = 8'h00;
    cur = D_RST;

    // Reset, then one cycle later still stable.
    @(negedge clk);
    resetn = 1'b0;
    push(edge_cnt + 1, D_RST, "reset");
    @(negedge clk);
    resetn = 1'b1;
    push(edge_cnt + 1, D_RST, "reset_stable");
    repeat (2) @(negedge clk);

    capture(8'h05, {BL, BL, BL, S5}, "x_5");
    x = 8'h00;
    enable = 1'b0;
    push(edge_cnt + 10, cur, "idle_hold_10");
    push(edge_cnt + 30, cur, "idle_hold_30");
    push(edge_cnt + 50, cur, "idle_hold_50");
    repeat (50) @(negedge clk);

    capture(8'h49, {BL, BL, S7, S3}, "x_73");
    capture(8'h85, {MI, S1, S2, S3}, "x_m123");
    capture(8'h80, {MI, S1, S2, S8}, "x_m128");
    capture(8'h7F, {BL, S1, S2, S7}, "x_127");
    capture(8'h00, {BL, BL, BL, S0}, "x_0");
    capture(8'hFF, {MI, BL, BL, S1}, "x_m1");
    capture(8'h0A, {BL, BL, S1, S0}, "x_10");
    capture(8'h64, {BL, S1, S0, S0}, "x_100");

    // Enable held high: x changed mid-conversion must not leak; recapture at N+10.
    e0 = edge_cnt;
    x = 8'h85;
    enable = 1'b1;
    push(e0 + 9, cur, "held_prev");
    push(e0 + 10, {MI, S1, S2, S3}, "held_first");
    repeat (3) @(negedge clk);
    x = 8'h0A;
    push(e0 + 19, {MI, S1, S2, S3}, "held_first_hold");
    push(e0 + 20, {BL, BL, S1, S0}, "held_second");
    while (edge_cnt < e0 + 20) @(negedge clk);
    enable = 1'b0;
    cur = {BL, BL, S1, S0};
    repeat (3) @(negedge clk);

    // Reset in the middle of a conversion aborts it.
    e0 = edge_cnt;
    x = 8'h7F;
    enable = 1'b1;
    push(e0 + 4, cur, "abort_prev");
    @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    push(edge_cnt + 1, D_RST, "abort_reset");
    @(negedge clk);
    resetn = 1'b1;
    push(edge_cnt + 1, D_RST, "abort_after");
    push(edge_cnt + 12, D_RST, "abort_idle");
    cur = D_RST;
    repeat (13) @(negedge clk);

    capture(8'h49, {BL, BL, S7, S3}, "post_abort_73");

    repeat (3) @(negedge clk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s: never checked (due edge %0d)", e.name, e.due);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
